// File: rtl/fifo_wr_arbiter.sv
`timescale 1ns/1ps
// fifo_wr_arbiter: round-robin burst arbiter feeding requesters into a FIFO write port
module fifo_wr_arbiter #(
    parameter int DSIZE    = 8,
    parameter int NREQ     = 4,
    parameter int MAXBURST = 4,
    localparam int GW      = $clog2(NREQ)
) (
    input  logic                  wclk,
    input  logic                  wrst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*DSIZE-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  wfull,
    output logic                  winc,
    output logic [DSIZE-1:0]      wdata,
    output logic                  active,
    output logic [GW-1:0]         gnt_id,
    output logic [15:0]           wr_count
);
    typedef enum logic {IDLE, BURST} state_t;
    state_t state;
    logic [GW-1:0] rr_ptr, sel, next_ptr;
    logic [4:0] beat_cnt;
    logic [2*NREQ-1:0] rv2;
    logic found, xfer, gnt_valid;
    logic [DSIZE-1:0] gnt_data;
    always_comb begin
        rv2 = {req_valid, req_valid} >> rr_ptr;
        found = 1'b0;
        sel = rr_ptr;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rv2[i]) begin
                found = 1'b1;
                sel = GW'((int'(rr_ptr) + i) % NREQ);
            end
        end
    end
    always_comb begin
        gnt_data = '0;
        for (int i = 0; i < NREQ; i++)
            if (GW'(i) == gnt_id) gnt_data = req_data[i*DSIZE +: DSIZE];
    end
    assign gnt_valid = req_valid[gnt_id];
    // reset forces the strobes low even if the registered state is still BURST
    assign xfer      = state == BURST && gnt_valid && !wfull && !wrst;
    assign winc      = xfer;
    assign wdata     = xfer ? gnt_data : '0;
    assign req_ready = xfer ? NREQ'(1) << gnt_id : '0;
    assign active    = state == BURST && !wrst;
    assign next_ptr  = gnt_id == GW'(NREQ - 1) ? '0 : gnt_id + 1'b1;
    always_ff @(posedge wclk) begin
        if (wrst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            gnt_id   <= '0;
            beat_cnt <= '0;
            wr_count <= '0;
        end else begin
            if (xfer && wr_count != 16'hFFFF) wr_count <= wr_count + 1'b1;
            if (state == IDLE) begin
                if (found) begin
                    gnt_id   <= sel;
                    beat_cnt <= '0;
                    state    <= BURST;
                end
            end else if (!gnt_valid) begin
                state  <= IDLE;
                rr_ptr <= next_ptr;
            end else if (xfer) begin
                beat_cnt <= beat_cnt + 1'b1;
                if (beat_cnt == 5'(MAXBURST - 1)) begin
                    state  <= IDLE;
                    rr_ptr <= next_ptr;
                end
            end
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
`timescale 1ns/1ps
// tb_fifo_wr_arbiter: directed scenario tests for fifo_wr_arbiter
module tb_fifo_wr_arbiter;
    logic        wclk = 1'b0;
    logic        wrst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ready;
    logic        wfull = 1'b0;
    logic        winc;
    logic [7:0]  wdata;
    logic        active;
    logic [1:0]  gnt_id;
    logic [15:0] wr_count;
    int total = 0;
    int bad = 0;

    fifo_wr_arbiter dut (
        .wclk(wclk), .wrst(wrst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .wfull(wfull), .winc(winc), .wdata(wdata),
        .active(active), .gnt_id(gnt_id), .wr_count(wr_count)
    );

    always #5 wclk = ~wclk;

    task automatic cyc();
        @(posedge wclk);
        #2;
    endtask

    task automatic test_reset();
        req_valid = 4'hF;
        req_data = 32'h44332211;
        for (int c = 0; c < 2; c++) begin
            cyc();
            #1;
            total++; if (winc !== 1'b0) begin bad++; $display("FAIL reset_winc got=%b want=0", winc); end
            total++; if (req_ready !== 4'h0) begin bad++; $display("FAIL reset_ready got=%h want=0", req_ready); end
            total++; if (active !== 1'b0) begin bad++; $display("FAIL reset_active got=%b want=0", active); end
            total++; if (gnt_id !== 2'd0) begin bad++; $display("FAIL reset_gnt got=%0d want=0", gnt_id); end
            total++; if (wr_count !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", wr_count); end
        end
        wrst = 1'b0;
        req_valid = '0;
        cyc();
    endtask

    task automatic test_single();
        logic [7:0] beats [3] = '{8'hA5, 8'h5A, 8'hFF};
        cyc();
        req_valid = 4'b0010;
        req_data = {16'h0, beats[0], 8'h00};
        #1;
        total++; if (winc !== 1'b0) begin bad++; $display("FAIL single_idle_winc got=%b want=0", winc); end
        for (int b = 0; b < 3; b++) begin
            cyc();
            req_data = {16'h0, beats[b], 8'h00};
            #1;
            total++; if (gnt_id !== 2'd1) begin bad++; $display("FAIL single_gnt got=%0d want=1", gnt_id); end
            total++; if (winc !== 1'b1) begin bad++; $display("FAIL single_winc beat=%0d got=%b want=1", b, winc); end
            total++; if (wdata !== beats[b]) begin bad++; $display("FAIL single_wdata beat=%0d got=%h want=%h", b, wdata, beats[b]); end
            total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL single_ready got=%b want=0010", req_ready); end
        end
        cyc();
        req_valid = '0;
        #1;
        total++; if (winc !== 1'b0 || wdata !== 8'h00) begin bad++; $display("FAIL single_drop got winc=%b wdata=%h want 0/00", winc, wdata); end
        cyc();
        #1;
        total++; if (active !== 1'b0) begin bad++; $display("FAIL single_end_active got=%b want=0", active); end
        total++; if (wr_count !== 16'd3) begin bad++; $display("FAIL single_count got=%0d want=3", wr_count); end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_d;
        cyc();
        wrst = 1'b1;
        cyc();
        wrst = 1'b0;
        req_valid = 4'hF;
        req_data = 32'h44332211;
        #1;
        total++; if (active !== 1'b0) begin bad++; $display("FAIL rr_start_active got=%b want=0", active); end
        for (int b = 0; b < 5; b++) begin
            exp_d = 8'(8'h11 * (b % 4 + 1));
            for (int k = 0; k < 4; k++) begin
                cyc();
                #1;
                total++; if (gnt_id !== 2'(b % 4)) begin bad++; $display("FAIL rr_gnt burst=%0d got=%0d want=%0d", b, gnt_id, b % 4); end
                total++; if (winc !== 1'b1 || wdata !== exp_d) begin bad++; $display("FAIL rr_beat burst=%0d beat=%0d got winc=%b wdata=%h want 1/%h", b, k, winc, wdata, exp_d); end
            end
            cyc();
            if (b == 4) req_valid = '0;
            #1;
            total++; if (active !== 1'b0 || winc !== 1'b0) begin bad++; $display("FAIL rr_gap burst=%0d got active=%b winc=%b want 0/0", b, active, winc); end
        end
        total++; if (wr_count !== 16'd20) begin bad++; $display("FAIL rr_count got=%0d want=20", wr_count); end
        cyc();
    endtask

    task automatic test_backpressure();
        cyc();
        req_valid = 4'b0001;
        req_data = 32'h000000C1;
        #1;
        total++; if (winc !== 1'b0) begin bad++; $display("FAIL bp_idle got=%b want=0", winc); end
        for (int k = 0; k < 2; k++) begin
            cyc();
            #1;
            total++; if (winc !== 1'b1 || gnt_id !== 2'd0) begin bad++; $display("FAIL bp_pre beat=%0d got winc=%b gnt=%0d want 1/0", k, winc, gnt_id); end
        end
        for (int k = 0; k < 3; k++) begin
            cyc();
            wfull = 1'b1;
            #1;
            total++; if (winc !== 1'b0 || req_ready !== 4'h0 || active !== 1'b1) begin bad++; $display("FAIL bp_stall cyc=%0d got winc=%b ready=%b active=%b want 0/0000/1", k, winc, req_ready, active); end
        end
        for (int k = 0; k < 2; k++) begin
            cyc();
            wfull = 1'b0;
            #1;
            total++; if (winc !== 1'b1 || wdata !== 8'hC1) begin bad++; $display("FAIL bp_post beat=%0d got winc=%b wdata=%h want 1/c1", k, winc, wdata); end
        end
        cyc();
        req_valid = '0;
        #1;
        total++; if (active !== 1'b0) begin bad++; $display("FAIL bp_end_active got=%b want=0", active); end
        total++; if (wr_count !== 16'd24) begin bad++; $display("FAIL bp_count got=%0d want=24", wr_count); end
    endtask

    task automatic test_reset_mid();
        cyc();
        req_valid = 4'b0010;
        req_data = 32'h0000A100;
        #1;
        cyc();
        #1;
        total++; if (winc !== 1'b1 || gnt_id !== 2'd1) begin bad++; $display("FAIL rm_beat1 got winc=%b gnt=%0d want 1/1", winc, gnt_id); end
        cyc();
        wrst = 1'b1;
        #1;
        total++; if (winc !== 1'b0 || active !== 1'b0 || req_ready !== 4'h0) begin bad++; $display("FAIL rm_in_reset got winc=%b active=%b ready=%b want 0/0/0000", winc, active, req_ready); end
        cyc();
        wrst = 1'b0;
        req_valid = 4'b1001;
        req_data = 32'hD300000D;
        #1;
        total++; if (active !== 1'b0 || winc !== 1'b0) begin bad++; $display("FAIL rm_idle got active=%b winc=%b want 0/0", active, winc); end
        total++; if (wr_count !== 16'd0) begin bad++; $display("FAIL rm_count got=%0d want=0", wr_count); end
        cyc();
        #1;
        total++; if (gnt_id !== 2'd0 || winc !== 1'b1 || wdata !== 8'h0D) begin bad++; $display("FAIL rm_regrant got gnt=%0d winc=%b wdata=%h want 0/1/0d", gnt_id, winc, wdata); end
        cyc();
        req_valid = '0;
        #1;
        cyc();
        #1;
        total++; if (active !== 1'b0 || wr_count !== 16'd1) begin bad++; $display("FAIL rm_end got active=%b count=%0d want 0/1", active, wr_count); end
    endtask

    task automatic test_early_drop();
        cyc();
        req_valid = 4'b1100;
        req_data = 32'hE3E20000;
        #1;
        for (int k = 0; k < 2; k++) begin
            cyc();
            #1;
            total++; if (gnt_id !== 2'd2 || winc !== 1'b1 || wdata !== 8'hE2) begin bad++; $display("FAIL ed_beat=%0d got gnt=%0d winc=%b wdata=%h want 2/1/e2", k, gnt_id, winc, wdata); end
        end
        cyc();
        req_valid = 4'b1000;
        wfull = 1'b1;
        #1;
        total++; if (winc !== 1'b0 || active !== 1'b1) begin bad++; $display("FAIL ed_drop got winc=%b active=%b want 0/1", winc, active); end
        cyc();
        wfull = 1'b0;
        #1;
        total++; if (active !== 1'b0 || winc !== 1'b0) begin bad++; $display("FAIL ed_gap got active=%b winc=%b want 0/0", active, winc); end
        cyc();
        #1;
        total++; if (gnt_id !== 2'd3 || winc !== 1'b1 || wdata !== 8'hE3) begin bad++; $display("FAIL ed_next got gnt=%0d winc=%b wdata=%h want 3/1/e3", gnt_id, winc, wdata); end
        cyc();
        req_valid = '0;
        #1;
        cyc();
        #1;
        total++; if (active !== 1'b0 || wr_count !== 16'd4) begin bad++; $display("FAIL ed_end got active=%b count=%0d want 0/4", active, wr_count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_early_drop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: wclk clocks all state; wrst, sampled on rising wclk, resets all state.
REQ-002 Parameter DSIZE, default 8: data width in bits, matching the FIFO write port.
REQ-003 Parameter NREQ, default 4: number of requesters (2..8).
REQ-004 Parameter MAXBURST, default 4: maximum beats per grant (1..16).
REQ-005 wclk  input  1  write-domain clock.
REQ-006 wrst  input  1  synchronous active-high reset.
REQ-007 req_valid  input  NREQ  per-requester data-valid.
REQ-008 req_data  input  NREQ*DSIZE  per-requester data; requester i occupies bits [i*DSIZE +: DSIZE].
REQ-009 req_ready  output  NREQ  per-requester accept strobe (one-hot or zero).
REQ-010 wfull  input  1  FIFO write-side full flag.
REQ-011 winc  output  1  FIFO write strobe.
REQ-012 wdata  output  DSIZE  FIFO write data.
REQ-013 active  output  1  high while in BURST.
REQ-014 gnt_id  output  clog2(NREQ)  currently or last granted requester index.
REQ-015 wr_count  output  16  total beats written, saturating at 16'hFFFF.

Function
REQ-016 The block SHALL implement a two-state FSM with states IDLE and BURST; the state, gnt_id, rr_ptr, beat_cnt and wr_count SHALL be registered.
REQ-017 In IDLE, if any req_valid bit is high, the block SHALL select the first valid index found searching upward from rr_ptr with wrap-around, load gnt_id with that index, clear beat_cnt and enter BURST on the next edge.
REQ-018 In IDLE, the block SHALL hold winc=0 and req_ready=0.
REQ-019 In BURST, the write condition xfer SHALL equal req_valid[gnt_id] AND NOT wfull, evaluated combinationally.
REQ-020 When xfer is high, winc SHALL be 1, req_ready[gnt_id] SHALL be 1, and wdata SHALL equal req_data of gnt_id, all in the same cycle; all other outputs SHALL stay combinational from the registered state.
REQ-021 When xfer is low, winc SHALL be 0, req_ready SHALL be 0 and wdata SHALL be 0.
REQ-022 Each xfer SHALL increment beat_cnt, and SHALL increment wr_count unless wr_count is 16'hFFFF.
REQ-023 While wfull is high in BURST, the block SHALL hold the grant and beat_cnt, with no timeout.
REQ-024 The block SHALL leave BURST for IDLE, setting rr_ptr = gnt_id+1 modulo NREQ, when either (a) xfer occurs with beat_cnt == MAXBURST-1, or (b) req_valid[gnt_id] is low.
REQ-025 When wfull is high in the same cycle that req_valid[gnt_id] drops, rule (b) SHALL take precedence.
REQ-026 Latency: a valid asserted in cycle t (block in IDLE) SHALL produce its first winc no earlier than cycle t+1.
REQ-027 Each burst end SHALL be followed by exactly one IDLE cycle before the next grant.
REQ-028 The block SHALL never drive winc while wfull is high.
REQ-029 The block SHALL never assert more than one req_ready bit.
REQ-030 active SHALL equal (state == BURST).

Reset
REQ-031 When wrst is high at a rising edge, state SHALL become IDLE and rr_ptr, gnt_id, beat_cnt and wr_count SHALL become 0, regardless of any burst in progress.
REQ-032 While the block is in reset, winc, req_ready and active SHALL be 0.
REQ-033 A beat presented in the same cycle that wrst is high SHALL NOT increment wr_count.

Verification
REQ-034 Reset: hold wrst=1 for 2 cycles with all req_valid=1 -> winc=0, req_ready=0, active=0, gnt_id=0, wr_count=0 throughout.
REQ-035 Single requester: req 1 presents A5, 5A, FF (valid held while each beat is accepted), then drops valid -> gnt_id=1, winc high for 3 cycles with wdata A5, 5A, FF; afterwards IDLE; wr_count=3.
REQ-036 Round-robin: all 4 requesters continuously valid -> grant order 0,1,2,3,0; exactly 4 winc per burst; 1 idle cycle between bursts; wr_count=20 after 5 bursts.
REQ-037 Backpressure: req 0 bursting, wfull=1 for 3 cycles after beat 2 -> winc=0 and req_ready=0 for those 3 cycles; beats 3-4 follow when wfull=0; burst totals 4.
REQ-038 Early drop: req 2 drops valid after 2 beats while req 3 is valid -> burst ends with 2 beats, IDLE for 1 cycle, gnt_id=3 next.
REQ-039 Reset mid-burst: wrst=1 for 1 cycle during beat 2 of req 1 -> next cycle IDLE, wr_count=0, no winc; the following grant goes to the lowest valid index from 0.
